// File: rtl/ram_req_initiator.sv
// Request-side initiator for the RAM simulation model: buffers client commands in a
// FIFO, issues them one at a time on the valid/ready port and returns in-order responses.
module ram_req_initiator #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_write,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rvalid,
  output logic [63:0] mem_raddr,
  input  logic        mem_readReady,
  input  logic        mem_readfin,
  input  logic [63:0] mem_rdata,
  output logic        mem_wvalid,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  input  logic        mem_writeReady,
  input  logic        mem_writefin,
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT) + 1;

  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_ONE_C   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST_C  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX_C   = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t            state_r, state_nx_s;
  logic              fifo_write_r [FIFO_DEPTH];
  logic [63:0]       fifo_addr_r  [FIFO_DEPTH];
  logic [63:0]       fifo_wdata_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_nx_s;
  logic [TO_W-1:0]   to_cnt_r;
  logic [63:0]       cur_addr_r, cur_wdata_r;
  logic              push_s, pop_s, to_inc_s, to_last_s;
  logic              resp_load_s, resp_write_nx_s, resp_err_nx_s, resp_done_s;
  logic [63:0]       resp_rdata_nx_s;
  logic              cmd_ready_r, busy_r, mem_rvalid_r, mem_wvalid_r;
  logic              resp_valid_r, resp_write_r, resp_err_r;
  logic [63:0]       resp_rdata_r;
  logic [31:0]       rd_count_r, wr_count_r;

  assign push_s    = cmd_valid && cmd_ready_r;
  assign to_last_s = (to_cnt_r >= TO_LAST_C);

  // FIFO occupancy after this edge
  always_comb begin
    count_nx_s = count_r;
    if (push_s && !pop_s) begin
      count_nx_s = count_r + CNT_ONE_C;
    end else if (!push_s && pop_s) begin
      count_nx_s = count_r - CNT_ONE_C;
    end else begin
      count_nx_s = count_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; an accept or fin in the same cycle as the timeout wins
  always_comb begin
    state_nx_s      = state_r;
    pop_s           = 1'b0;
    to_inc_s        = 1'b0;
    resp_load_s     = 1'b0;
    resp_write_nx_s = 1'b0;
    resp_err_nx_s   = 1'b0;
    resp_rdata_nx_s = 64'd0;
    resp_done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != CNT_ZERO_C) begin
          pop_s      = 1'b1;
          state_nx_s = fifo_write_r[rd_ptr_r] ? WR_REQ : RD_REQ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_readReady) begin
          state_nx_s = RD_WAIT;
          to_inc_s   = 1'b1;
        end else if (to_last_s) begin
          state_nx_s    = RESP;
          resp_load_s   = 1'b1;
          resp_err_nx_s = 1'b1;
        end else begin
          to_inc_s = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_readfin) begin
          state_nx_s      = RESP;
          resp_load_s     = 1'b1;
          resp_rdata_nx_s = mem_rdata;
        end else if (to_last_s) begin
          state_nx_s    = RESP;
          resp_load_s   = 1'b1;
          resp_err_nx_s = 1'b1;
        end else begin
          to_inc_s = 1'b1;
        end
      end
      WR_REQ: begin
        resp_write_nx_s = 1'b1;
        if (mem_writeReady) begin
          state_nx_s = WR_WAIT;
          to_inc_s   = 1'b1;
        end else if (to_last_s) begin
          state_nx_s    = RESP;
          resp_load_s   = 1'b1;
          resp_err_nx_s = 1'b1;
        end else begin
          to_inc_s = 1'b1;
        end
      end
      WR_WAIT: begin
        resp_write_nx_s = 1'b1;
        if (mem_writefin) begin
          state_nx_s  = RESP;
          resp_load_s = 1'b1;
        end else if (to_last_s) begin
          state_nx_s    = RESP;
          resp_load_s   = 1'b1;
          resp_err_nx_s = 1'b1;
        end else begin
          to_inc_s = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nx_s  = IDLE;
          resp_done_s = 1'b1;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // command FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_write_r[i] <= 1'b0;
        fifo_addr_r[i]  <= 64'd0;
        fifo_wdata_r[i] <= 64'd0;
      end
    end else begin
      if (push_s) begin
        fifo_write_r[wr_ptr_r] <= cmd_write;
        fifo_addr_r[wr_ptr_r]  <= cmd_addr;
        fifo_wdata_r[wr_ptr_r] <= cmd_wdata;
        wr_ptr_r               <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_nx_s;
    end
  end

  // current command, timeout counter, registered outputs and completion counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_r   <= 64'd0;
      cur_wdata_r  <= 64'd0;
      to_cnt_r     <= '0;
      mem_rvalid_r <= 1'b0;
      mem_wvalid_r <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_write_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 64'd0;
      rd_count_r   <= 32'd0;
      wr_count_r   <= 32'd0;
      busy_r       <= 1'b0;
      cmd_ready_r  <= 1'b1;
    end else begin
      if (pop_s) begin
        cur_addr_r  <= fifo_addr_r[rd_ptr_r];
        cur_wdata_r <= fifo_wdata_r[rd_ptr_r];
        to_cnt_r    <= '0;
      end else if (to_inc_s && (to_cnt_r != TO_MAX_C)) begin
        to_cnt_r <= to_cnt_r + TO_ONE_C;
      end
      mem_rvalid_r <= (state_nx_s == RD_REQ);
      mem_wvalid_r <= (state_nx_s == WR_REQ);
      resp_valid_r <= (state_nx_s == RESP);
      if (resp_load_s) begin
        resp_write_r <= resp_write_nx_s;
        resp_err_r   <= resp_err_nx_s;
        resp_rdata_r <= resp_rdata_nx_s;
      end
      if (resp_done_s && !resp_err_r) begin
        if (resp_write_r) begin
          wr_count_r <= wr_count_r + 32'd1;
        end else begin
          rd_count_r <= rd_count_r + 32'd1;
        end
      end
      busy_r      <= (state_nx_s != IDLE) || (count_nx_s != CNT_ZERO_C);
      cmd_ready_r <= (count_nx_s < DEPTH_C);
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign busy       = busy_r;
  assign mem_rvalid = mem_rvalid_r;
  assign mem_wvalid = mem_wvalid_r;
  assign mem_raddr  = cur_addr_r;
  assign mem_waddr  = cur_addr_r;
  assign mem_wdata  = cur_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_write = resp_write_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign rd_count   = rd_count_r;
  assign wr_count   = wr_count_r;

endmodule

// File: tb/tb_ram_req_initiator.sv
// Bench for ram_req_initiator: behavioural RAM model plus a response scoreboard.
module tb_ram_req_initiator;

  localparam int TB_TIMEOUT = 32;

  typedef struct packed {
    logic        w;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [63:0] cmd_addr, cmd_wdata;
  logic        resp_valid, resp_ready, resp_write, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rvalid, mem_readReady, mem_readfin;
  logic [63:0] mem_raddr, mem_rdata;
  logic        mem_wvalid, mem_writeReady, mem_writefin;
  logic [63:0] mem_waddr, mem_wdata;
  logic        busy;
  logic [31:0] rd_count, wr_count;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  int   exp_rd = 0;
  int   exp_wr = 0;
  logic [63:0] ram [logic [63:0]];
  int   rd_stall = 0;
  int   fin_delay = 1;
  bit   wr_fin_en = 1'b1;
  bit   sink_en = 1'b1;
  bit   overlap_seen = 1'b0;

  ram_req_initiator #(.FIFO_DEPTH(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rvalid(mem_rvalid), .mem_raddr(mem_raddr), .mem_readReady(mem_readReady),
    .mem_readfin(mem_readfin), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_writeReady(mem_writeReady), .mem_writefin(mem_writefin),
    .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // RAM model: acts on the falling edge so its inputs are stable at the rising edge
  task automatic ram_model();
    int rd_wait = 0, wr_wait = 0, fin_cnt = 0;
    bit rd_offer = 0, wr_offer = 0, pend = 0, pend_wr = 0;
    logic [63:0] pend_addr = 64'd0;
    forever begin
      @(negedge clk);
      mem_readfin  = 1'b0;
      mem_writefin = 1'b0;
      mem_rdata    = 64'hA5A5_A5A5_A5A5_A5A5;
      if (mem_rvalid && mem_wvalid) overlap_seen = 1'b1;
      if (!rst_n) begin
        rd_wait = 0; wr_wait = 0; fin_cnt = 0;
        rd_offer = 0; wr_offer = 0; pend = 0;
        mem_readReady = 1'b0; mem_writeReady = 1'b0;
      end else begin
        if (rd_offer) begin
          pend = 1; pend_wr = 0; pend_addr = mem_raddr; fin_cnt = fin_delay;
        end
        if (wr_offer) begin
          ram[mem_waddr] = mem_wdata;
          if (wr_fin_en) begin
            pend = 1; pend_wr = 1; fin_cnt = fin_delay;
          end
        end
        rd_offer = 0;
        wr_offer = 0;
        if (pend) begin
          fin_cnt--;
          if (fin_cnt <= 0) begin
            pend = 0;
            if (pend_wr) mem_writefin = 1'b1;
            else begin
              mem_readfin = 1'b1;
              mem_rdata = ram.exists(pend_addr) ? ram[pend_addr] : 64'd0;
            end
          end
        end
        if (mem_rvalid) begin
          rd_wait++;
          mem_readReady = (rd_wait > rd_stall);
          rd_offer = mem_readReady;
        end else begin
          rd_wait = 0;
          mem_readReady = 1'b0;
        end
        if (mem_wvalid) begin
          wr_wait++;
          mem_writeReady = 1'b1;
          wr_offer = 1;
        end else begin
          wr_wait = 0;
          mem_writeReady = 1'b0;
        end
      end
    end
  endtask

  // response sink: drives resp_ready and checks each accepted response against the scoreboard
  task automatic resp_sink();
    exp_t e;
    forever begin
      @(negedge clk);
      resp_ready = sink_en;
      if (rst_n && resp_valid && sink_en) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp: got w=%0b rdata=%h err=%0b, want no response",
                   resp_write, resp_rdata, resp_err);
        end else begin
          e = sb_q.pop_front();
          if ({resp_write, resp_rdata, resp_err} !== {e.w, e.rdata, e.err}) begin
            bad++;
            $display("FAIL resp_check: got w=%0b rdata=%h err=%0b, want w=%0b rdata=%h err=%0b",
                     resp_write, resp_rdata, resp_err, e.w, e.rdata, e.err);
          end
        end
      end
    end
  endtask

  // called at a falling edge; returns at the falling edge after the accepting rising edge
  task automatic push_cmd(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] er, input logic ee, output int waited);
    exp_t e;
    waited = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      total++; bad++;
      $display("FAIL push_timeout: cmd_ready stuck at %0b, want 1", cmd_ready);
    end else begin
      e.w = w; e.rdata = er; e.err = ee;
      sb_q.push_back(e);
      if (!ee) begin
        if (w) exp_wr++;
        else exp_rd++;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sb_q.size());
    end
    repeat (2) @(negedge clk);
    total++;
    if ({rd_count, wr_count} !== {exp_rd[31:0], exp_wr[31:0]}) begin
      bad++;
      $display("FAIL %s_counts: got rd=%0d wr=%0d, want rd=%0d wr=%0d",
               name, rd_count, wr_count, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({cmd_ready, busy, mem_rvalid, mem_wvalid, resp_valid, resp_write, resp_err} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_flags: got %b, want 1000000",
               {cmd_ready, busy, mem_rvalid, mem_wvalid, resp_valid, resp_write, resp_err});
    end
    total++;
    if ({resp_rdata, mem_raddr, mem_waddr, mem_wdata, rd_count, wr_count} !== 320'd0) begin
      bad++;
      $display("FAIL reset_data: got rdata=%h raddr=%h wdata=%h rd=%0d wr=%0d, want all 0",
               resp_rdata, mem_raddr, mem_wdata, rd_count, wr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_ready, busy, resp_valid} !== 3'b100) begin
      bad++;
      $display("FAIL reset_release: got ready/busy/rvalid=%b, want 100", {cmd_ready, busy, resp_valid});
    end
  endtask

  task automatic test_single_read();
    int w, n;
    ram[64'h1000] = 64'hDEAD_BEEF_0000_0001;
    fin_delay = 5; rd_stall = 0; sink_en = 1'b1;
    push_cmd(1'b0, 64'h1000, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, w);
    total++;
    if ({mem_rvalid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL single_after_push: got rvalid/busy=%b, want 01", {mem_rvalid, busy});
    end
    @(negedge clk);
    total++;
    if ({mem_rvalid, mem_raddr} !== {1'b1, 64'h1000}) begin
      bad++;
      $display("FAIL single_req: got rvalid=%0b raddr=%h, want 1 %h", mem_rvalid, mem_raddr, 64'h1000);
    end
    n = 1;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 7) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles, want 7", n);
    end
    wait_empty("single");
  endtask

  task automatic test_write_read();
    int w;
    fin_delay = 2; overlap_seen = 1'b0;
    push_cmd(1'b1, 64'h40, 64'h1234, 64'd0, 1'b0, w);
    push_cmd(1'b0, 64'h40, 64'd0, 64'h1234, 1'b0, w);
    wait_empty("wr_rd");
    total++;
    if (overlap_seen !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_overlap: got rvalid&wvalid seen=%0b, want 0", overlap_seen);
    end
  endtask

  task automatic test_back_to_back();
    int w, nr;
    int r[3];
    logic prev;
    r = '{0, 0, 0}; nr = 0; prev = 1'b0;
    ram[64'h300] = 64'h0123_4567_89AB_CDEF;
    fin_delay = 1;
    push_cmd(1'b0, 64'h300, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, w);
    push_cmd(1'b1, 64'h318, 64'h55, 64'd0, 1'b0, w);
    push_cmd(1'b0, 64'h318, 64'd0, 64'h55, 1'b0, w);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid && !prev && nr < 3) begin
        r[nr] = k;
        nr++;
      end
      prev = resp_valid;
    end
    total++;
    if (nr != 3 || r[0] != 1) begin
      bad++;
      $display("FAIL b2b_first: got %0d responses, first at %0d, want 3 and 1", nr, r[0]);
    end
    total++;
    if (r[1] - r[0] != 4 || r[2] - r[1] != 4) begin
      bad++;
      $display("FAIL b2b_spacing: got gaps %0d %0d, want 4 4", r[1] - r[0], r[2] - r[1]);
    end
    wait_empty("b2b");
  endtask

  task automatic test_backpressure();
    int w, n, unstable;
    fin_delay = 2; rd_stall = 20; unstable = 0;
    push_cmd(1'b0, 64'h1000, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, w);
    n = 0;
    while (!mem_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(mem_rvalid === 1'b1 && mem_raddr === 64'h1000)) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL bp_stable: got %0d unstable cycles, want 0", unstable);
    end
    @(negedge clk);
    total++;
    if (mem_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop: got rvalid=%0b after accept, want 0", mem_rvalid);
    end
    rd_stall = 0;
    wait_empty("bp");
  endtask

  task automatic test_fifo_full();
    int w, wsum;
    fin_delay = 1; sink_en = 1'b0; wsum = 0;
    for (int i = 0; i < 5; i++) begin
      ram[64'h200 + 64'(i * 8)] = 64'hF00D_0000_0000_0000 + 64'(i);
      push_cmd(1'b0, 64'h200 + 64'(i * 8), 64'd0, 64'hF00D_0000_0000_0000 + 64'(i), 1'b0, w);
      wsum += w;
    end
    total++;
    if (wsum != 0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready: got waits=%0d cmd_ready=%0b, want 0 0", wsum, cmd_ready);
    end
    repeat (10) @(negedge clk);
    total++;
    if ({cmd_ready, resp_valid, busy} !== 3'b011) begin
      bad++;
      $display("FAIL full_hold: got ready/rvalid/busy=%b, want 011", {cmd_ready, resp_valid, busy});
    end
    sink_en = 1'b1;
    wait_empty("full");
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL full_idle: got ready/busy=%b, want 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_timeout();
    int w, n, k;
    fin_delay = 1; wr_fin_en = 1'b0;
    push_cmd(1'b1, 64'h500, 64'h77, 64'd0, 1'b1, w);
    push_cmd(1'b0, 64'h40, 64'd0, 64'h1234, 1'b0, w);
    n = 0;
    while (!mem_wvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != TB_TIMEOUT || resp_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_latency: got %0d cycles err=%0b, want %0d 1", k, resp_err, TB_TIMEOUT);
    end
    wr_fin_en = 1'b1;
    wait_empty("timeout");
  endtask

  task automatic test_reset_mid();
    int w, n, seen;
    fin_delay = 10;
    for (int i = 0; i < 3; i++) begin
      push_cmd(1'b0, 64'h40, 64'd0, 64'h1234, 1'b0, w);
    end
    n = 0;
    while (!mem_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (mem_rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, busy, mem_rvalid, mem_wvalid, resp_valid, resp_err} !== 6'b100000 ||
        {rd_count, wr_count, resp_rdata} !== 128'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got flags=%b rd=%0d wr=%0d, want 100000 0 0",
               {cmd_ready, busy, mem_rvalid, mem_wvalid, resp_valid, resp_err}, rd_count, wr_count);
    end
    sb_q.delete();
    exp_rd = 0; exp_wr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (resp_valid || busy || mem_rvalid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got %0d active cycles after reset, want 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 64'd0; cmd_wdata = 64'd0;
    resp_ready = 1'b0;
    mem_readReady = 1'b0; mem_readfin = 1'b0; mem_rdata = 64'd0;
    mem_writeReady = 1'b0; mem_writefin = 1'b0;
    fork
      ram_model();
      resp_sink();
    join_none
    repeat (3) @(negedge clk);
    test_reset();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
